router_pkt_tx: RTL and testbench

ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

---
 rtl/router_pkg.sv | 30 +++
 rtl/router_pkt_buf.sv | 45 ++++
 rtl/router_pkt_tx.sv | 153 +++++++++++++++
 tb/tb_router_pkt_tx.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the router packet transmitter: FSM states,
// header field layout and build constants.
package router_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HDR,
    PLD,
    PAR,
    CHK,
    DONE
  } state_t;

  localparam int ADDR_LSB        = 0;
  localparam int ADDR_MSB        = 1;
  localparam int LEN_LSB         = 2;
  localparam int LEN_MSB         = 7;
  localparam int MAX_LEN_DEFAULT = 63;
  localparam int CHK_CYCLES      = 2;

  function automatic logic [7:0] make_hdr(input logic [5:0] l, input logic [1:0] d);
    logic [7:0] h;
    h = '0;
    h[LEN_MSB:LEN_LSB]   = l;
    h[ADDR_MSB:ADDR_LSB] = d;
    return h;
  endfunction

endpackage

// File: rtl/router_pkt_buf.sv
// Payload store for router_pkt_tx: DEPTH x 8 array with write/read pointers.
// rd_next looks one entry ahead so the transmitter can register the next byte.
module router_pkt_buf
  import router_pkg::*;
#(
  parameter int DEPTH = MAX_LEN_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic [7:0] rd_next,
  output logic [5:0] wr_ptr,
  output logic [5:0] rd_ptr
);

  logic [7:0] mem [DEPTH];
  logic [5:0] rd_ptr_nxt;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 6'd1;
      if (rd_en) rd_ptr <= rd_ptr + 6'd1;
    end
  end

  assign rd_ptr_nxt = rd_ptr + 6'd1;
  assign rd_data    = mem[rd_ptr];
  assign rd_next    = (32'(rd_ptr_nxt) < DEPTH) ? mem[rd_ptr_nxt] : '0;

endmodule

// File: rtl/router_pkt_tx.sv
// Router packet transmitter: buffers a payload, then sends header, payload
// and XOR parity. Optional post-parity error check under ROUTER_PKT_TX_ERR_CHECK_EN.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] dest,
  input  logic [5:0] len,
  input  logic [7:0] pl_data,
  input  logic       pl_valid,
  output logic       pl_ready,
  input  logic       busy,
  input  logic       err,
  output logic       packet_valid,
  output logic [7:0] pkt_data,
  output logic       done,
  output logic       cfg_err,
  output logic       err_seen
);

  state_t     state;
  logic [1:0] dest_q;
  logic [5:0] len_q;
  logic [7:0] parity;
  logic       start_ok, buf_clr, wr_en, rd_en, last_wr, last_rd;
  logic [5:0] wr_ptr, rd_ptr;
  logic [7:0] rd_data, rd_next;

`ifdef ROUTER_PKT_TX_ERR_CHECK_EN
  logic [1:0] chk_cnt;
`else
  logic unused_err;
  assign unused_err = err;
  assign err_seen   = 1'b0;
`endif

  assign start_ok = (len != '0) && (32'(len) <= MAX_LEN) && (dest != 2'd3);
  assign buf_clr  = (state == IDLE) && start && start_ok;
  assign wr_en    = (state == LOAD) && pl_valid && pl_ready;
  assign last_wr  = (wr_ptr == len_q - 6'd1);
  assign last_rd  = (rd_ptr == len_q - 6'd1);
  assign rd_en    = (state == PLD) && !busy && !last_rd;

  router_pkt_buf #(.DEPTH(MAX_LEN)) u_buf (
    .clk     (clk),
    .reset   (reset),
    .clr     (buf_clr),
    .wr_en   (wr_en),
    .wr_data (pl_data),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .rd_next (rd_next),
    .wr_ptr  (wr_ptr),
    .rd_ptr  (rd_ptr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      pl_ready     <= 1'b0;
      packet_valid <= 1'b0;
      pkt_data     <= '0;
      done         <= 1'b0;
      cfg_err      <= 1'b0;
      dest_q       <= '0;
      len_q        <= '0;
      parity       <= '0;
`ifdef ROUTER_PKT_TX_ERR_CHECK_EN
      chk_cnt      <= '0;
      err_seen     <= 1'b0;
`endif
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (start_ok) begin
              dest_q   <= dest;
              len_q    <= len;
              parity   <= '0;
              pl_ready <= 1'b1;
              state    <= LOAD;
`ifdef ROUTER_PKT_TX_ERR_CHECK_EN
              err_seen <= 1'b0;
`endif
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (wr_en && last_wr) begin
            pl_ready     <= 1'b0;
            packet_valid <= 1'b1;
            pkt_data     <= make_hdr(len_q, dest_q);
            state        <= HDR;
          end
        end
        HDR: begin
          if (!busy) begin
            parity   <= pkt_data;
            pkt_data <= rd_data;
            state    <= PLD;
          end
        end
        // pkt_data always holds the byte being offered, so parity folds it in on consume.
        PLD: begin
          if (!busy) begin
            parity <= parity ^ pkt_data;
            if (last_rd) begin
              packet_valid <= 1'b0;
              pkt_data     <= parity ^ pkt_data;
              state        <= PAR;
            end else begin
              pkt_data <= rd_next;
            end
          end
        end
        PAR: begin
          if (!busy) begin
            pkt_data <= '0;
`ifdef ROUTER_PKT_TX_ERR_CHECK_EN
            chk_cnt  <= '0;
            state    <= CHK;
`else
            done     <= 1'b1;
            state    <= DONE;
`endif
          end
        end
`ifdef ROUTER_PKT_TX_ERR_CHECK_EN
        CHK: begin
          if (err) err_seen <= 1'b1;
          if (chk_cnt == 2'(CHK_CYCLES - 1)) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            chk_cnt <= chk_cnt + 2'd1;
          end
        end
`endif
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx: directed scenarios plus random packets
// compared cycle by cycle against an expected byte-stream model.
module tb_router_pkt_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] dest;
  logic [5:0] len;
  logic [7:0] pl_data;
  logic       pl_valid;
  logic       pl_ready;
  logic       busy;
  logic       err;
  logic       packet_valid;
  logic [7:0] pkt_data;
  logic       done;
  logic       cfg_err;
  logic       err_seen;

  int checks = 0;
  int errors = 0;
  logic       exp_err_seen = 1'b0;
  logic [7:0] pl [64];

`ifdef ROUTER_PKT_TX_ERR_CHECK_EN
  localparam int CHK_N = 2;
`else
  localparam int CHK_N = 0;
`endif

  router_pkt_tx #(.MAX_LEN(63)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .dest         (dest),
    .len          (len),
    .pl_data      (pl_data),
    .pl_valid     (pl_valid),
    .pl_ready     (pl_ready),
    .busy         (busy),
    .err          (err),
    .packet_valid (packet_valid),
    .pkt_data     (pkt_data),
    .done         (done),
    .cfg_err      (cfg_err),
    .err_seen     (err_seen)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_pv"}, 32'(packet_valid), 0);
    check({tag, "_data"}, 32'(pkt_data), 0);
    check({tag, "_rdy"}, 32'(pl_ready), 0);
    check({tag, "_done"}, 32'(done), 0);
  endtask

  task automatic cfg_reject(input logic [1:0] d, input logic [5:0] n);
    start = 1'b1; dest = d; len = n;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    check("cfg_err_pulse", 32'(cfg_err), 1);
    check_idle("cfg_rej1");
    @(posedge clk); @(negedge clk);
    check("cfg_err_clear", 32'(cfg_err), 0);
    check_idle("cfg_rej2");
  endtask

  // vmode: 0 always valid, 1 valid every other cycle, 2 random gaps (with ignored starts)
  // bmode: 0 never busy, 1 random busy, 2 busy 3 cycles on the second payload byte
  task automatic send_pkt(input logic [1:0] d, input logic [5:0] n, input int vmode,
                          input int bmode, input int abort_k, input logic [1:0] emask);
    logic [7:0] exp_b [66];
    logic [7:0] par;
    int nl, idx, hold, cyc, guard;
    logic b;
    nl = int'(n);
    exp_b[0] = {n, d};
    par = exp_b[0];
    for (int i = 0; i < nl; i++) begin
      exp_b[i+1] = pl[i];
      par ^= pl[i];
    end
    exp_b[nl+1] = par;
    cyc = 0;

    start = 1'b1; dest = d; len = n;
    @(posedge clk); cyc++;
    @(negedge clk);
    start = 1'b0; dest = 2'($urandom); len = 6'($urandom);
    exp_err_seen = 1'b0;
`ifndef ROUTER_PKT_TX_ERR_CHECK_EN
    err = emask[0];
`endif

    idx = 0; guard = 0;
    while (idx < nl && guard < 1000) begin
      check("ld_ready", 32'(pl_ready), 1);
      check("ld_pv", 32'(packet_valid), 0);
      check("ld_data", 32'(pkt_data), 0);
      check("ld_cfg_err", 32'(cfg_err), 0);
      check("ld_err_seen", 32'(err_seen), 32'(exp_err_seen));
      case (vmode)
        0:       pl_valid = 1'b1;
        1:       pl_valid = (guard % 2 == 0);
        default: pl_valid = 1'($urandom);
      endcase
      pl_data = pl_valid ? pl[idx] : 8'($urandom);
      if (vmode == 2) begin
        start = 1'($urandom);
        dest  = 2'd3;
      end
      @(posedge clk); cyc++;
      if (pl_valid) idx++;
      guard++;
      @(negedge clk);
      pl_valid = 1'b0;
      start    = 1'b0;
    end
    check("ld_complete", 32'(idx), 32'(nl));

    for (int k = 0; k <= nl + 1; k++) begin
      hold = 0;
      do begin
        if (k == abort_k) begin
          reset = 1'b1;
          #1;
          check_idle("abort");
          check("abort_err_seen", 32'(err_seen), 0);
          exp_err_seen = 1'b0;
          @(posedge clk); @(negedge clk);
          reset = 1'b0;
          err   = 1'b0;
          for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_idle("post_abort");
          end
          return;
        end
        check("tx_pv", 32'(packet_valid), (k <= nl) ? 1 : 0);
        check("tx_data", 32'(pkt_data), 32'(exp_b[k]));
        check("tx_rdy", 32'(pl_ready), 0);
        check("tx_done", 32'(done), 0);
        case (bmode)
          1:       b = ($urandom_range(0, 3) == 0);
          2:       b = (k == 2 && hold < 3);
          default: b = 1'b0;
        endcase
        busy = b;
        @(posedge clk); cyc++; hold++;
        @(negedge clk);
        busy = 1'b0;
      end while (b && hold < 50);
      if (bmode == 2 && k == 2) check("busy_hold_cycles", 32'(hold), 4);
    end

`ifdef ROUTER_PKT_TX_ERR_CHECK_EN
    for (int c = 0; c < 2; c++) begin
      check_idle("chk");
      check("chk_err_seen", 32'(err_seen), 32'(exp_err_seen));
      err = emask[c];
      @(posedge clk); cyc++;
      @(negedge clk);
      if (err) exp_err_seen = 1'b1;
      err = 1'b0;
    end
`endif

    check("done_pulse", 32'(done), 1);
    check("done_pv", 32'(packet_valid), 0);
    check("done_data", 32'(pkt_data), 0);
    check("done_err_seen", 32'(err_seen), 32'(exp_err_seen));
    if (vmode == 0 && bmode == 0) check("latency", 32'(cyc), 32'(2 * nl + 3 + CHK_N));
    @(posedge clk); @(negedge clk);
    err = 1'b0;
    check_idle("after_done");
    check("after_err_seen", 32'(err_seen), 32'(exp_err_seen));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; dest = '0; len = '0;
    pl_data = '0; pl_valid = 1'b0; busy = 1'b0; err = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    check("reset_cfg_err", 32'(cfg_err), 0);
    check("reset_err_seen", 32'(err_seen), 0);
    reset = 1'b0;
    @(negedge clk);

    // Basic 3-byte packet, no back-pressure
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    send_pkt(2'd1, 6'd3, 0, 0, -1, 2'b00);

    // Same packet with busy held during 0x22
    send_pkt(2'd1, 6'd3, 0, 2, -1, 2'b00);

    // Rejected requests
    cfg_reject(2'd3, 6'd3);
    cfg_reject(2'd1, 6'd0);

    // Full-length packet with pl_valid toggling
    for (int i = 0; i < 63; i++) pl[i] = 8'($urandom);
    send_pkt(2'd2, 6'd63, 1, 0, -1, 2'b00);

    // Reset while presenting the third of five payload bytes
    for (int i = 0; i < 5; i++) pl[i] = 8'($urandom);
    send_pkt(2'd0, 6'd5, 0, 0, 3, 2'b00);
    pl[0] = 8'($urandom);
    send_pkt(2'd1, 6'd1, 0, 0, -1, 2'b00);

    // Router error flagged in the second check cycle
    pl[0] = 8'hA5; pl[1] = 8'h5A;
    send_pkt(2'd0, 6'd2, 0, 0, -1, 2'b10);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("err_seen_sticky", 32'(err_seen), 32'(exp_err_seen));
    end
    for (int i = 0; i < 4; i++) pl[i] = 8'($urandom);
    send_pkt(2'd2, 6'd4, 2, 1, -1, 2'b00);

    // Random packets
    for (int t = 0; t < 20; t++) begin
      logic [1:0] rd;
      logic [5:0] rl;
      rd = 2'($urandom_range(0, 2));
      rl = 6'($urandom_range(1, 63));
      for (int i = 0; i < 63; i++) pl[i] = 8'($urandom);
      send_pkt(rd, rl, $urandom_range(0, 2), $urandom_range(0, 1), -1, 2'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
